sysid_checker: RTL and testbench



---
 rtl/sysid_pkg.sv | 20 ++
 rtl/sysid_checker_timer.sv | 24 ++
 rtl/sysid_checker.sv | 162 ++++++++++++++++
 tb/tb_sysid_checker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the system-ID checker: FSM encoding, Avalon word addresses, default build values.
// No logic here; imported by the checker top.
package sysid_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_DELAY = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'h500D_1B92;

endpackage

// File: rtl/sysid_checker_timer.sv
`timescale 1ns/1ps
// Loadable 16-bit down-counter with zero flag; load has priority, counting stops at zero.
// Shared between the start delay and the read-response timeout; the owner applies reset through i_load.
module avm_read_timer (
  input  logic        clock,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_dec,
  output logic        o_zero
);

  logic [15:0] r_cnt;

  always_ff @(posedge clock) begin
    if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 16'd0)) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_zero = (r_cnt == 16'd0);

endmodule

// File: rtl/sysid_checker.sv
`timescale 1ns/1ps
// Avalon-MM read master: reads system-ID words 0 and 1, compares against build values, latches status.
// done rises START_DELAY+5 cycles after reset/start with a zero-wait slave; waitrequest stalls the request indefinitely.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS = DEF_EXPECTED_TS,
  parameter bit          CHECK_TS    = 1'b1,
  parameter int unsigned START_DELAY = 16,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] DELAY_LOAD = 16'(START_DELAY - 1);
  localparam logic [15:0] TMO_LOAD   = 16'(TIMEOUT);
  localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

  state_t      r_state;
  logic        r_addr;
  logic        r_early_vld;
  logic [31:0] r_early_dat;
  logic        r_id_match;
  logic        r_ts_match;
  logic        r_pass;
  logic        r_timeout_err;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic [7:0]  r_retry;

  logic        w_accept;
  logic        w_rsp_vld;
  logic [31:0] w_rsp_dat;
  logic        w_tmr_zero;
  logic        w_tmr_load;
  logic [15:0] w_tmr_val;
  logic        w_tmr_dec;
  logic        w_retry_go;
  logic        w_restart;
  logic        w_id_eq;
  logic        w_ts_eq;

  // A zero-latency response is parked at acceptance and consumed in WAIT like a late one.
  assign w_accept   = (r_state == ST_REQ) && !avm_waitrequest;
  assign w_rsp_vld  = (r_state == ST_WAIT) && (r_early_vld || avm_readdatavalid);
  assign w_rsp_dat  = r_early_vld ? r_early_dat : avm_readdata;
  assign w_retry_go = (r_state == ST_WAIT) && !w_rsp_vld && w_tmr_zero && (r_retry < RETRY_MAX);
  assign w_restart  = ((r_state == ST_DONE) && start) || w_retry_go;

  assign w_tmr_load = reset || w_restart || w_accept;
  assign w_tmr_val  = (w_accept && !reset) ? TMO_LOAD : DELAY_LOAD;
  assign w_tmr_dec  = (r_state == ST_DELAY) || (r_state == ST_WAIT);

  assign w_id_eq = (r_id_value == EXPECTED_ID);
  assign w_ts_eq = (r_ts_value == EXPECTED_TS);

  avm_read_timer u_timer (
    .clock      (clock),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_DELAY;
      r_addr        <= SYSID_ADDR_ID;
      r_early_vld   <= 1'b0;
      r_early_dat   <= 32'd0;
      r_id_match    <= 1'b0;
      r_ts_match    <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_id_value    <= 32'd0;
      r_ts_value    <= 32'd0;
      r_retry       <= 8'd0;
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (w_tmr_zero) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (w_accept) begin
            r_state     <= ST_WAIT;
            r_early_vld <= avm_readdatavalid;
            r_early_dat <= avm_readdata;
          end
        end
        ST_WAIT: begin
          if (w_rsp_vld) begin
            r_early_vld <= 1'b0;
            if (r_addr == SYSID_ADDR_ID) begin
              r_id_value <= w_rsp_dat;
              r_addr     <= SYSID_ADDR_TS;
              r_state    <= ST_REQ;
            end else begin
              r_ts_value <= w_rsp_dat;
              r_state    <= ST_CHECK;
            end
          end else if (w_tmr_zero) begin
            if (w_retry_go) begin
              r_retry <= r_retry + 8'd1;
              r_addr  <= SYSID_ADDR_ID;
              r_state <= ST_DELAY;
            end else begin
              r_timeout_err <= 1'b1;
              r_state       <= ST_DONE;
            end
          end
        end
        ST_CHECK: begin
          r_id_match <= w_id_eq;
          r_ts_match <= w_ts_eq;
          r_pass     <= w_id_eq && (w_ts_eq || !CHECK_TS);
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (start) begin
            r_id_match    <= 1'b0;
            r_ts_match    <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_retry       <= 8'd0;
            r_addr        <= SYSID_ADDR_ID;
            r_state       <= ST_DELAY;
          end
        end
        default: r_state <= ST_DELAY;
      endcase
    end
  end

  assign avm_read    = (r_state == ST_REQ);
  assign avm_address = r_addr;
  assign done        = (r_state == ST_DONE);
  assign busy        = (r_state != ST_DONE);
  assign id_match    = r_id_match;
  assign ts_match    = r_ts_match;
  assign pass        = r_pass;
  assign timeout_err = r_timeout_err;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_checker.sv
`timescale 1ns/1ps
// Bench for sysid_checker: behavioural Avalon slave, expected results queued per sequence, monitor compares on done rise.
module tb_sysid_checker;

  localparam int unsigned SD = 4;
  localparam logic [31:0] TS_OK = 32'h500D_1B92;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic waitreq = 1'b0;
  logic rdv = 1'b0;
  logic [31:0] rdata = 32'd0;

  logic a0_addr, a0_read, busy0, done0, idm0, tsm0, pass0, terr0;
  logic [31:0] idv0, tsv0;
  logic a1_addr, a1_read, busy1, done1, idm1, tsm1, pass1, terr1;
  logic [31:0] idv1, tsv1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sysid_checker #(.CHECK_TS(1'b1), .START_DELAY(SD), .TIMEOUT(10), .MAX_RETRY(3)) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(a0_addr), .avm_read(a0_read), .avm_waitrequest(waitreq),
    .avm_readdatavalid(rdv), .avm_readdata(rdata),
    .busy(busy0), .done(done0), .id_match(idm0), .ts_match(tsm0), .pass(pass0),
    .timeout_err(terr0), .id_value(idv0), .ts_value(tsv0)
  );

  // Same slave traffic, timestamp comparison informational only.
  sysid_checker #(.CHECK_TS(1'b0), .START_DELAY(SD), .TIMEOUT(10), .MAX_RETRY(3)) dut_nots (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(a1_addr), .avm_read(a1_read), .avm_waitrequest(waitreq),
    .avm_readdatavalid(rdv), .avm_readdata(rdata),
    .busy(busy1), .done(done1), .id_match(idm1), .ts_match(tsm1), .pass(pass1),
    .timeout_err(terr1), .id_value(idv1), .ts_value(tsv1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model configuration and bookkeeping
  int cfg_wait = 0;
  int cfg_lat = 0;
  int cfg_resp_from = 0;
  logic [31:0] cfg_id = 32'd0;
  logic [31:0] cfg_ts = TS_OK;
  int stall_left = 0;
  int pend_cnt = 0;
  int acc0 = 0;
  int acc1 = 0;
  int stall_seen = 0;
  int stall_bad = 0;
  bit req_seen = 0;
  logic req_addr = 1'b0;
  logic [31:0] pend_dat = 32'd0;

  always @(negedge clock) begin
    rdv = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rdv = 1'b1;
        rdata = pend_dat;
      end
    end
    if (a0_read === 1'b1) begin
      if (!req_seen) begin
        req_seen = 1;
        stall_left = cfg_wait;
        req_addr = a0_addr;
      end else if (a0_addr !== req_addr) begin
        stall_bad++;
      end
      if (stall_left > 0) begin
        waitreq = 1'b1;
        stall_left--;
        stall_seen++;
      end else begin
        waitreq = 1'b0;
        req_seen = 0;
        if (a0_addr == 1'b0) acc0++; else acc1++;
        if (acc0 >= cfg_resp_from) begin
          if (cfg_lat == 0) begin
            rdv = 1'b1;
            rdata = a0_addr ? cfg_ts : cfg_id;
          end else begin
            pend_cnt = cfg_lat;
            pend_dat = a0_addr ? cfg_ts : cfg_id;
          end
        end
      end
    end else begin
      if (req_seen) stall_bad++;
      req_seen = 0;
      waitreq = 1'b0;
    end
  end

  // Scoreboard
  typedef struct packed {
    logic idm, tsm, pass, pass_nc, terr;
    logic [31:0] idv, tsv;
  } exp_t;
  exp_t sb[$];
  logic prev_done = 1'b0;

  task automatic push_exp(input logic idm, input logic tsm, input logic ps, input logic ps_nc,
                          input logic terr, input logic [31:0] idv, input logic [31:0] tsv);
    exp_t e;
    e.idm = idm; e.tsm = tsm; e.pass = ps; e.pass_nc = ps_nc; e.terr = terr;
    e.idv = idv; e.tsv = tsv;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (done0 === 1'b1 && !prev_done) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("id_match", idm0, e.idm);
        chk("ts_match", tsm0, e.tsm);
        chk("pass", pass0, e.pass);
        chk("timeout_err", terr0, e.terr);
        chk("id_value", idv0, e.idv);
        chk("ts_value", tsv0, e.tsv);
        chk("done_nots", done1, 1'b1);
        chk("pass_nots", pass1, e.pass_nc);
      end
    end
    prev_done = (done0 === 1'b1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lim, output int n);
    n = 0;
    while (done0 !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk(name, done0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset state
    repeat (3) tick();
    chk("rst_avm_read", a0_read, 1'b0);
    chk("rst_avm_address", a0_addr, 1'b0);
    chk("rst_busy", busy0, 1'b1);
    chk("rst_done", done0, 1'b0);
    chk("rst_id_match", idm0, 1'b0);
    chk("rst_ts_match", tsm0, 1'b0);
    chk("rst_pass", pass0, 1'b0);
    chk("rst_timeout_err", terr0, 1'b0);
    chk("rst_id_value", idv0, 32'd0);
    chk("rst_ts_value", tsv0, 32'd0);

    // Zero-wait, zero-latency slave: pass with exact done timing
    push_exp(1, 1, 1, 1, 0, 32'd0, TS_OK);
    @(negedge clock);
    reset = 1'b0;
    wait_done("t1_done", 100, n);
    chk("t1_done_latency", n, SD + 5);

    // Timestamp off by one
    cfg_ts = 32'h500D_1B93;
    push_exp(1, 0, 0, 1, 0, 32'd0, 32'h500D_1B93);
    pulse_start();
    chk("t2_done_drop", done0, 1'b0);
    wait_done("t2_done", 100, n);
    chk("t2_ts_match_nots", tsm1, 1'b0);

    // Waitrequest stalls and delayed readdatavalid
    cfg_ts = TS_OK;
    cfg_wait = 7;
    cfg_lat = 2;
    stall_seen = 0;
    stall_bad = 0;
    push_exp(1, 1, 1, 1, 0, 32'd0, TS_OK);
    pulse_start();
    wait_done("t4_done", 200, n);
    chk("t4_stall_stable", stall_bad, 0);
    chk("t4_stall_cycles", stall_seen, 14);

    // Silent slave: four attempts then timeout
    cfg_wait = 0;
    cfg_lat = 0;
    cfg_resp_from = 1000;
    acc0 = 0;
    acc1 = 0;
    push_exp(0, 0, 0, 0, 1, 32'd0, TS_OK);
    pulse_start();
    wait_done("t5_done", 400, n);
    chk("t5_reads_addr0", acc0, 4);
    chk("t5_reads_addr1", acc1, 0);

    // Response only from the third attempt
    cfg_resp_from = 3;
    acc0 = 0;
    acc1 = 0;
    push_exp(1, 1, 1, 1, 0, 32'd0, TS_OK);
    pulse_start();
    wait_done("t6_done", 400, n);
    chk("t6_reads_addr0", acc0, 3);
    chk("t6_reads_addr1", acc1, 1);

    // Rerun after pass with a changed ID
    cfg_resp_from = 0;
    cfg_id = 32'h0000_0001;
    push_exp(0, 1, 0, 0, 0, 32'h0000_0001, TS_OK);
    pulse_start();
    chk("t7_done_drop", done0, 1'b0);
    chk("t7_busy", busy0, 1'b1);
    wait_done("t7_done", 100, n);

    // Start while busy has no effect on timing or result
    cfg_id = 32'd0;
    push_exp(1, 1, 1, 1, 0, 32'd0, TS_OK);
    pulse_start();
    fork
      wait_done("t8_done", 100, n);
      begin
        @(negedge clock);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    join
    chk("t8_done_latency", n, SD + 5);
    repeat (3) tick();
    chk("t8_done_held", done0, 1'b1);

    // Reset while waiting for readdatavalid
    cfg_lat = 3;
    push_exp(1, 1, 1, 1, 0, 32'd0, TS_OK);
    pulse_start();
    n = 0;
    while (a0_read !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("t9_read_seen", a0_read, 1'b1);
    tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("t9_avm_read", a0_read, 1'b0);
    chk("t9_done", done0, 1'b0);
    chk("t9_pass", pass0, 1'b0);
    chk("t9_id_match", idm0, 1'b0);
    chk("t9_ts_value", tsv0, 32'd0);
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b0;
    wait_done("t9_done_rerun", 200, n);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
